// File: rtl/seg7_pkg.sv
// Shared constants for the six-digit stopwatch display: segment patterns
// ({g,f,e,d,c,b,a}, active-high), digit count and slot encoding.
package seg7_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [2:0] slot_t;
   localparam slot_t SLOT_FIRST = 3'd0;
   localparam slot_t SLOT_LAST  = 3'd5;

   typedef logic [6:0] seg_t;
   localparam seg_t SEG_0    = 7'b0111111;
   localparam seg_t SEG_1    = 7'b0000110;
   localparam seg_t SEG_2    = 7'b1011011;
   localparam seg_t SEG_3    = 7'b1001111;
   localparam seg_t SEG_4    = 7'b1100110;
   localparam seg_t SEG_5    = 7'b1101101;
   localparam seg_t SEG_6    = 7'b1111101;
   localparam seg_t SEG_7    = 7'b0000111;
   localparam seg_t SEG_8    = 7'b1111111;
   localparam seg_t SEG_9    = 7'b1101111;
   localparam seg_t SEG_DASH = 7'b1000000;
   localparam seg_t SEG_OFF  = 7'b0000000;

   // Non-BCD codes render as a dash so a corrupted counter is visible, never blank.
   function automatic seg_t seg7_pattern(input logic [3:0] bcd);
      seg_t pat;
      case (bcd)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high pattern {g,f,e,d,c,b,a}.
// Output polarity is handled by the caller.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = seg7_pattern(bcd_i);
   end

endmodule

// File: rtl/seg7_scan.sv
// Six-digit multiplexed 7-segment driver: per-frame snapshot of mm:ss:cc,
// left-to-right scan with one dead cycle per slot, lap freeze and mh blanking.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV    = 1000,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit AN_ACT_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] mh,
   input  logic [3:0] ml,
   input  logic [3:0] sh,
   input  logic [3:0] sl,
   input  logic [3:0] msh,
   input  logic [3:0] msl,
   input  logic       freeze,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic       dp,
   output logic [5:0] an,
   output logic       frame_done
);

   localparam int                PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [6:0]        SEG_IDLE = SEG_ACT_LOW ? 7'h7F : 7'h00;
   localparam logic              DP_IDLE  = SEG_ACT_LOW ? 1'b1  : 1'b0;
   localparam logic [5:0]        AN_IDLE  = AN_ACT_LOW  ? 6'h3F : 6'h00;

   logic [PRE_W-1:0]                 pre_q, pre_d;
   slot_t                            slot_q, slot_d;
   logic [NUM_DIGITS-1:0][3:0]       shadow_q, shadow_d;
   logic                             load_pend_q, load_pend_d;
   logic [6:0]                       seg_q, seg_d;
   logic                             dp_q, dp_d;
   logic [5:0]                       an_q, an_d;
   logic                             frame_done_q, frame_done_d;

   logic                             wrap;
   logic                             load;
   logic [2:0]                       digit_idx;
   logic [3:0]                       digit;
   logic [6:0]                       pat;
   logic                             blank;
   logic [6:0]                       seg_ah;
   logic [5:0]                       an_ah;
   logic                             dp_ah;

   // Slot k shows digit 5-k, so the shadow index equals the anode bit.
   always_comb begin
      digit_idx = 3'd5 - slot_q;
      digit     = shadow_q[digit_idx];
   end

   bcd_to_seg7 u_dec (
      .bcd_i (digit),
      .seg_o (pat)
   );

   always_comb begin
      wrap        = (pre_q == PRE_LAST) && (slot_q == SLOT_LAST);
      load        = (wrap || load_pend_q) && !freeze;
      load_pend_d = load_pend_q && !load;

      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      slot_d = slot_q;
      if (pre_q == PRE_LAST) begin
         slot_d = (slot_q == SLOT_LAST) ? SLOT_FIRST : slot_q + 1'b1;
      end

      shadow_d = shadow_q;
      if (load) begin
         shadow_d = {mh, ml, sh, sl, msh, msl};
      end
   end

   // Output stage: decode the current slot, apply blanking, dead time and polarity.
   always_comb begin
      blank  = blank_lz && (slot_q == SLOT_FIRST) && (shadow_q[5] == 4'd0);
      seg_ah = blank ? SEG_OFF : pat;
      dp_ah  = (slot_q == 3'd1) || (slot_q == 3'd3);

      an_ah = '0;
      if (pre_q != '0) begin
         an_ah[digit_idx] = 1'b1;
      end

      seg_d        = SEG_ACT_LOW ? ~seg_ah : seg_ah;
      dp_d         = SEG_ACT_LOW ? ~dp_ah  : dp_ah;
      an_d         = AN_ACT_LOW  ? ~an_ah  : an_ah;
      frame_done_d = wrap;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pre_q        <= '0;
         slot_q       <= SLOT_FIRST;
         shadow_q     <= '0;
         load_pend_q  <= 1'b1;
         seg_q        <= SEG_IDLE;
         dp_q         <= DP_IDLE;
         an_q         <= AN_IDLE;
         frame_done_q <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         slot_q       <= slot_d;
         shadow_q     <= shadow_d;
         load_pend_q  <= load_pend_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule
